// File: rtl/pixel_filter_pkg.sv
// Shared mode encoding and helpers for the pixel filter bank and its channels.
package pixel_filter_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_BRIGHT = 2'b01,
    MODE_THRESH = 2'b10,
    MODE_INVERT = 2'b11
  } filt_mode_t;

  function automatic int unsigned pix_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/pixel_filter_channel.sv
// One filter channel: frame-latched controls, mode datapath on the S1 pixel,
// and a saturating per-frame sum that yields the mean of the last completed frame.
module pixel_filter_channel
  import pixel_filter_pkg::*;
#(
  parameter int BITS           = 8,
  parameter int GAIN_SHIFT     = 6,
  parameter int LOG2_FRAME_PIX = 17
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            latch_en,
  input  logic            enable_new,
  input  filt_mode_t      mode_new,
  input  logic [7:0]      bpm_new,
  input  logic [BITS-1:0] pix,
  output logic [BITS-1:0] result,
  input  logic            beat,
  input  logic            beat_sof,
  input  logic [BITS-1:0] beat_pix,
  output logic [BITS-1:0] brightness
);

  localparam int PW = BITS + 9;
  localparam int SW = BITS + LOG2_FRAME_PIX;
  localparam logic [BITS-1:0] PIX_MAX   = BITS'(pix_max(BITS));
  localparam logic [PW-1:0]   PIX_MAX_W = PW'(pix_max(BITS));
  localparam logic [8:0]      GAIN_ONE  = 9'(2 ** GAIN_SHIFT);

  logic            enable_q;
  filt_mode_t      mode_q;
  logic [7:0]      bpm_q;
  logic [PW-1:0]   product;
  logic [PW-1:0]   scaled;
  logic [BITS-1:0] thresh;
  logic [SW:0]     sum_ext;
  logic [SW-1:0]   sum_sat;
  logic [SW-1:0]   sum_q;
  logic            seen_sof;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q <= 1'b0;
      mode_q   <= MODE_BYPASS;
      bpm_q    <= '0;
    end else if (latch_en) begin
      enable_q <= enable_new;
      mode_q   <= mode_new;
      bpm_q    <= bpm_new;
    end
  end

  always_comb begin
    product = PW'(pix) * PW'({1'b0, bpm_q} + GAIN_ONE);
    scaled  = product >> GAIN_SHIFT;
    thresh  = PIX_MAX - BITS'(bpm_q);
    result  = pix;
    if (enable_q) begin
      case (mode_q)
        MODE_BRIGHT: result = (scaled > PIX_MAX_W) ? PIX_MAX : scaled[BITS-1:0];
        MODE_THRESH: result = (pix >= thresh) ? PIX_MAX : '0;
        MODE_INVERT: result = PIX_MAX - pix;
        default:     result = pix;
      endcase
    end
  end

  assign sum_ext = {1'b0, sum_q} + (SW+1)'(beat_pix);
  assign sum_sat = sum_ext[SW] ? '1 : sum_ext[SW-1:0];

  // The sum gathered before the first sof is not a real frame, so it is never published.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q      <= '0;
      seen_sof   <= 1'b0;
      brightness <= '0;
    end else if (beat) begin
      if (beat_sof) begin
        if (seen_sof) brightness <= sum_q[SW-1 -: BITS];
        seen_sof <= 1'b1;
        sum_q    <= SW'(beat_pix);
      end else begin
        sum_q <= sum_sat;
      end
    end
  end

endmodule

// File: rtl/pixel_filter_bank.sv
// N-channel lockstep pixel filter bank with a two-stage valid/ready pipeline
// (S1 holds the accepted pixel, S2 registers all channel results).
module pixel_filter_bank
  import pixel_filter_pkg::*;
#(
  parameter int BITS           = 8,
  parameter int NUM_CH         = 2,
  parameter int MAX_BPM        = 200,
  parameter int GAIN_SHIFT     = 6,
  parameter int LOG2_FRAME_PIX = 17
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BITS-1:0]        pix_in,
  input  logic                   valid_in,
  input  logic                   sof_in,
  output logic                   module_ready,
  input  logic [NUM_CH-1:0]      filter_enable,
  input  logic [2*NUM_CH-1:0]    mode,
  input  logic [7:0]             BPM_estimate,
  output logic [BITS*NUM_CH-1:0] pix_out,
  output logic                   valid_out,
  output logic                   sof_out,
  input  logic                   output_ready,
  output logic [BITS*NUM_CH-1:0] brightness
);

  logic                   s1_v;
  logic                   s1_sof;
  logic [BITS-1:0]        s1_pix;
  logic                   s2_load;
  logic                   in_beat;
  logic                   out_beat;
  logic                   latch_en;
  logic [7:0]             bpm_c;
  logic [BITS*NUM_CH-1:0] result;

  // S1 may refill whenever it is empty or is moving into S2 this cycle.
  assign s2_load      = !valid_out || output_ready;
  assign module_ready = !s1_v || s2_load;
  assign in_beat      = valid_in && module_ready;
  assign out_beat     = valid_out && output_ready;
  assign latch_en     = in_beat && sof_in;
  assign bpm_c        = (BPM_estimate > 8'(MAX_BPM)) ? 8'(MAX_BPM) : BPM_estimate;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v   <= 1'b0;
      s1_sof <= 1'b0;
      s1_pix <= '0;
    end else if (module_ready) begin
      s1_v <= valid_in;
      if (valid_in) begin
        s1_pix <= pix_in;
        s1_sof <= sof_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
      pix_out   <= '0;
    end else if (s2_load) begin
      valid_out <= s1_v;
      if (s1_v) begin
        pix_out <= result;
        sof_out <= s1_sof;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pixel_filter_channel #(
      .BITS          (BITS),
      .GAIN_SHIFT    (GAIN_SHIFT),
      .LOG2_FRAME_PIX(LOG2_FRAME_PIX)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .latch_en  (latch_en),
      .enable_new(filter_enable[k]),
      .mode_new  (filt_mode_t'(mode[2*k +: 2])),
      .bpm_new   (bpm_c),
      .pix       (s1_pix),
      .result    (result[BITS*k +: BITS]),
      .beat      (out_beat),
      .beat_sof  (sof_out),
      .beat_pix  (pix_out[BITS*k +: BITS]),
      .brightness(brightness[BITS*k +: BITS])
    );
  end

endmodule
